// File: rtl/evac_pkg.sv
// Package: sizing helper, default parameters and the lane entry type shared by the
// evacuation priority queue, its lanes and its bench.
package evac_pkg;

  localparam int ZONE_W_DEF   = 8;
  localparam int NUM_PRIO_DEF = 4;
  localparam int DEPTH_DEF    = 4;
  localparam int CTR8_W       = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  localparam int PRIO_W_DEF = clog2(NUM_PRIO_DEF);

  typedef struct packed {
    logic [ZONE_W_DEF-1:0] zone;
    logic [PRIO_W_DEF-1:0] prio;
  } lane_entry_t;

endpackage

// File: rtl/evac_fifo_lane.sv
// Module: evac_fifo_lane
// One priority lane: circular buffer with occupancy count and a fall-through head.
module evac_fifo_lane
  import evac_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] data_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               push_ok, pop_ok;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full lane only fits when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (pop_ok && !push_ok) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/evac_priority_queue.sv
// Module: evac_priority_queue
// Multi-lane evacuation request queue serving the highest-priority head; define
// EVAC_AGING_EN to let long-waiting lanes turn urgent after AGE_LIMIT foreign grants.
module evac_priority_queue
  import evac_pkg::*;
#(
  parameter int  ZONE_W    = ZONE_W_DEF,
  parameter int  NUM_PRIO  = NUM_PRIO_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  parameter int  AGE_LIMIT = 8,
  localparam int PRIO_W    = clog2(NUM_PRIO),
  localparam int COUNT_W   = clog2(NUM_PRIO * DEPTH + 1)
) (
  input  logic                Main_Clock,
  input  logic                Reset_n,
  input  logic                Clear,
  input  logic                Insert,
  input  logic [ZONE_W-1:0]   Zone,
  input  logic [PRIO_W-1:0]   Priority,
  input  logic                Serve,
  output logic [ZONE_W-1:0]   Output_Zone,
  output logic [PRIO_W-1:0]   Output_Priority,
  output logic                Empty,
  output logic [NUM_PRIO-1:0] Lane_Full,
  output logic [COUNT_W-1:0]  Item_Count,
  output logic                Overflow,
  output logic [CTR8_W-1:0]   Drop_Count
);

  localparam int ENTRY_W = ZONE_W + PRIO_W;

  if ((NUM_PRIO < 2) || ((NUM_PRIO & (NUM_PRIO - 1)) != 0) ||
      (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AGE_LIMIT < 1) || (AGE_LIMIT > 255)) begin : g_param_check
    $error("evac_priority_queue: illegal parameter set");
  end

  logic [NUM_PRIO-1:0] lane_empty, lane_full, lane_push, lane_pop, lane_urgent;
  logic [ENTRY_W-1:0]  lane_head [NUM_PRIO];
  logic [PRIO_W-1:0]   sel_idx;
  logic                sel_valid, serve_ok, insert_ok, drop;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [CTR8_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                overflow_q;

  assign lane_push = Insert ? (NUM_PRIO'(1) << Priority) : '0;

  for (genvar g = 0; g < NUM_PRIO; g++) begin : g_lane
    evac_fifo_lane #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
    ) u_lane (
      .clk_i   (Main_Clock),
      .rst_ni  (Reset_n),
      .clear_i (Clear),
      .push_i  (lane_push[g]),
      .pop_i   (lane_pop[g]),
      .data_i  ({Zone, Priority}),
      .head_o  (lane_head[g]),
      .empty_o (lane_empty[g]),
      .full_o  (lane_full[g])
    );
  end

  // Highest non-empty lane wins, unless some lane is urgent; then the highest urgent lane wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (!lane_empty[i]) begin
        sel_valid = 1'b1;
        sel_idx   = PRIO_W'(i);
      end
    end
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (lane_urgent[i]) begin
        sel_idx = PRIO_W'(i);
      end
    end
  end

  assign serve_ok  = Serve && sel_valid;
  assign lane_pop  = serve_ok ? (NUM_PRIO'(1) << sel_idx) : '0;
  assign insert_ok = Insert && (!lane_full[Priority] || lane_pop[Priority]);
  assign drop      = Insert && !insert_ok;

  always_comb begin
    Output_Zone     = '0;
    Output_Priority = '0;
    if (sel_valid) begin
      {Output_Zone, Output_Priority} = lane_head[sel_idx];
    end
  end

  always_comb begin
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (insert_ok && !serve_ok) begin
      count_d = count_q + COUNT_W'(1);
    end else if (serve_ok && !insert_ok) begin
      count_d = count_q - COUNT_W'(1);
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CTR8_W'(1);
    end
  end

  always_ff @(posedge Main_Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (Clear) begin
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= drop;
    end
  end

`ifdef EVAC_AGING_EN
  logic [CTR8_W-1:0] age_q [NUM_PRIO];
  logic [CTR8_W-1:0] age_d [NUM_PRIO];

  always_comb begin
    for (int i = 0; i < NUM_PRIO; i++) begin
      lane_urgent[i] = !lane_empty[i] && (age_q[i] >= CTR8_W'(AGE_LIMIT));
    end
  end

  // Age counts grants given to other lanes while this one waits.
  always_comb begin
    for (int i = 0; i < NUM_PRIO; i++) begin
      age_d[i] = age_q[i];
      if (lane_empty[i] || lane_pop[i]) begin
        age_d[i] = '0;
      end else if (serve_ok && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + CTR8_W'(1);
      end
    end
  end

  always_ff @(posedge Main_Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        age_q[i] <= '0;
      end
    end else if (Clear) begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  assign lane_urgent = '0;
`endif

  assign Empty      = &lane_empty;
  assign Lane_Full  = lane_full;
  assign Item_Count = count_q;
  assign Overflow   = overflow_q;
  assign Drop_Count = drop_cnt_q;

endmodule
